// File: rtl/maxpool_relu_pkg.sv
// Shared definitions for the CNN front end: the state type that both this
// pooling stage and the convolution stage use, and the default geometry for a
// 28x28 image convolved with a 3x3 kernel (26x26 feature map, 2x2 pooling).
package maxpool_relu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pool_state_e;

  localparam int IM_DIM   = 26;
  localparam int POOL_DIM = 2;

endpackage

// File: rtl/pool_row_buffer.sv
// Holds one row of horizontal pair maxima until the odd row arrives.
// Ports:
//   clk_i    - clock
//   we_i     - write enable
//   waddr_i  - write index (col/2)
//   wdata_i  - pair maximum to store
//   raddr_i  - read index (col/2)
//   rdata_o  - combinational read data
module pool_row_buffer #(
  parameter int depth      = 13,
  parameter int data_width = 8,
  parameter int addr_w     = 4
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [addr_w-1:0]     waddr_i,
  input  logic [data_width-1:0] wdata_i,
  input  logic [addr_w-1:0]     raddr_i,
  output logic [data_width-1:0] rdata_o
);

  logic [data_width-1:0] mem_q [depth];

  // NOTE: no reset on the array; every entry is rewritten on each even row
  // before the odd row reads it, so reset would only cost flop area.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/maxpool_relu.sv
// ReLU followed by 2x2 stride-2 max pooling over a raster-order feature map.
// Ports:
//   clk_i          - clock
//   rst_ni         - asynchronous active-low reset
//   pixel_i        - signed convolution result, raster order
//   pix_data_valid - pixel_i valid (always consumed, no backpressure)
//   pixel_o        - pooled, rectified pixel (holds between emissions)
//   pixel_o_valid  - one-cycle pulse per pooled pixel
//   pool_finished  - one-cycle pulse with the last pooled pixel of a frame
module maxpool_relu
  import maxpool_relu_pkg::*;
#(
  parameter int data_width = 8,
  parameter int im_dim     = IM_DIM,
  parameter int pool_dim   = POOL_DIM
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [data_width-1:0] pixel_i,
  input  logic                  pix_data_valid,
  output logic [data_width-1:0] pixel_o,
  output logic                  pixel_o_valid,
  output logic                  pool_finished
);

  localparam int half_dim = im_dim / 2;
  localparam int cnt_w    = (im_dim > 4) ? $clog2(im_dim) : 2;
  localparam int addr_w   = cnt_w - 1;

  if ((im_dim % 2) != 0 || pool_dim != 2) begin : g_bad_param
    $error("maxpool_relu: im_dim must be even and pool_dim must be 2");
  end

  pool_state_e           state_q, state_d;
  logic [cnt_w-1:0]      col_q, col_d, row_q, row_d;
  logic [data_width-1:0] hold_q, hold_d;
  logic [data_width-1:0] pixel_q, pixel_d;
  logic                  valid_q, valid_d;
  logic                  finished_q, finished_d;

  logic [data_width-1:0] pix_relu, pair_max, pool_max, buf_rdata;
  logic [addr_w-1:0]     buf_addr;
  logic                  col_last, row_last, buf_we;

  // Negative values (MSB set) clamp to zero; after this everything is unsigned.
  assign pix_relu = pixel_i[data_width-1] ? '0 : pixel_i;
  assign pair_max = (pix_relu > hold_q) ? pix_relu : hold_q;
  assign pool_max = (buf_rdata > pair_max) ? buf_rdata : pair_max;

  assign col_last = (col_q == cnt_w'(im_dim - 1));
  assign row_last = (row_q == cnt_w'(im_dim - 1));
  assign buf_addr = col_q[cnt_w-1:1];
  assign buf_we   = pix_data_valid & ~row_q[0] & col_q[0];

  pool_row_buffer #(
    .depth      (half_dim),
    .data_width (data_width),
    .addr_w     (addr_w)
  ) u_row_buffer (
    .clk_i   (clk_i),
    .we_i    (buf_we),
    .waddr_i (buf_addr),
    .wdata_i (pair_max),
    .raddr_i (buf_addr),
    .rdata_o (buf_rdata)
  );

  // NOTE: every variable gets its hold value first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    hold_d  = hold_q;
    pixel_d = pixel_q;
    valid_d = 1'b0;

    if (pix_data_valid) begin
      if (!col_q[0]) hold_d = pix_relu;
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      // Odd row, odd col completes a 2x2 window.
      if (row_q[0] && col_q[0]) begin
        pixel_d = pool_max;
        valid_d = 1'b1;
      end
    end

    // The datapath accepts input in every state; the FSM only tracks framing.
    case (state_q)
      IDLE:    if (pix_data_valid) state_d = RUN;
      RUN:     if (pix_data_valid && row_last && col_last) state_d = DONE;
      DONE:    state_d = RUN;
      default: state_d = IDLE;
    endcase

    finished_d = (state_d == DONE);
  end

  // NOTE: non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      hold_q     <= '0;
      pixel_q    <= '0;
      valid_q    <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      hold_q     <= hold_d;
      pixel_q    <= pixel_d;
      valid_q    <= valid_d;
      finished_q <= finished_d;
    end
  end

  assign pixel_o       = pixel_q;
  assign pixel_o_valid = valid_q;
  assign pool_finished = finished_q;

endmodule

// File: tb/tb_maxpool_relu.sv
// Scoreboard bench for maxpool_relu: a frame model computes each window
// maximum as its last input is driven; a negedge monitor pops and compares.
module tb_maxpool_relu;
  import maxpool_relu_pkg::*;

  localparam int DIM   = 26;
  localparam int N_OUT = (DIM / 2) * (DIM / 2);

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b1;
  logic [7:0] pixel_i = '0;
  logic       pix_data_valid = 1'b0;
  logic [7:0] pixel_o;
  logic       pixel_o_valid;
  logic       pool_finished;

  always #5 clk_i = ~clk_i;

  maxpool_relu #(.data_width(8), .im_dim(DIM), .pool_dim(2)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .pixel_i        (pixel_i),
    .pix_data_valid (pix_data_valid),
    .pixel_o        (pixel_o),
    .pixel_o_valid  (pixel_o_valid),
    .pool_finished  (pool_finished)
  );

  typedef struct {
    logic [7:0] val;
    logic       last;
    int         cyc;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         n_pulse = 0;
  int         n_fin = 0;
  logic [7:0] last_val = '0;
  logic [7:0] first_val = '0;
  int         br = 0;
  int         bc = 0;
  bit         gaps_on = 1'b0;
  logic [7:0] img [DIM][DIM];
  logic [7:0] win [4] = '{8'h80, 8'h03, 8'h7F, 8'hFF};

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] relu(input logic [7:0] v);
    return v[7] ? 8'd0 : v;
  endfunction

  function automatic logic [7:0] max2(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

  // Drive one valid pixel (optionally preceded by random idle cycles) and
  // push the expected result when it completes a window.
  task automatic drive(input logic [7:0] v);
    exp_t e;
    @(negedge clk_i);
    while (gaps_on && ($urandom_range(99) < 30)) begin
      pix_data_valid = 1'b0;
      pixel_i        = 8'($urandom);
      @(negedge clk_i);
    end
    pixel_i        = v;
    pix_data_valid = 1'b1;
    img[br][bc]    = v;
    if (br[0] && bc[0]) begin
      e.val  = max2(max2(relu(img[br-1][bc-1]), relu(img[br-1][bc])),
                    max2(relu(img[br][bc-1]), relu(v)));
      e.last = (br == DIM - 1) && (bc == DIM - 1);
      e.cyc  = cyc + 1;
      sb_q.push_back(e);
    end
    if (bc == DIM - 1) begin
      bc = 0;
      br = (br == DIM - 1) ? 0 : br + 1;
    end else begin
      bc = bc + 1;
    end
  endtask

  // kind 0: ramp, 1: constant -5, 2: random with a fixed first window
  task automatic send_frame(input int kind, input int n_inputs);
    for (int i = 0; i < n_inputs; i++) begin
      int r;
      int c;
      logic [7:0] v;
      r = i / DIM;
      c = i % DIM;
      case (kind)
        0:       v = 8'((r * DIM + c) % 128);
        1:       v = 8'hFB;
        default: v = 8'($urandom);
      endcase
      if (kind == 2 && r < 2 && c < 2) v = win[r * 2 + c];
      drive(v);
    end
  endtask

  task automatic drain(input string tag);
    @(negedge clk_i);
    pix_data_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk_i);
    end
    @(negedge clk_i);
    check(tag, sb_q.size(), 0);
  endtask

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      last_val = '0;
    end else if (pixel_o_valid) begin
      check("pulse_expected", 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        check("pixel", pixel_o, mon_e.val);
        check("finished", pool_finished, mon_e.last);
        check("latency_cycle", cyc, mon_e.cyc);
      end
      if (n_pulse == 0) first_val = pixel_o;
      n_pulse++;
      if (pool_finished) n_fin++;
      last_val = pixel_o;
    end else begin
      check("pixel_hold", pixel_o, last_val);
      check("finished_idle", pool_finished, 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: run did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    #1 rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("rst_pixel", pixel_o, 0);
    check("rst_valid", pixel_o_valid, 0);
    check("rst_finished", pool_finished, 0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));

    // Ramp frame, continuous valid
    n_pulse = 0; n_fin = 0;
    send_frame(0, DIM * DIM);
    drain("ramp_drain");
    check("ramp_count", n_pulse, N_OUT);
    check("ramp_finished_count", n_fin, 1);
    check("ramp_first", first_val, 27);

    // Full frame of -5 rectifies to all zeros
    n_pulse = 0; n_fin = 0;
    send_frame(1, DIM * DIM);
    drain("neg_drain");
    check("neg_count", n_pulse, N_OUT);
    check("neg_last", last_val, 0);

    // Random frame whose first window is {-128, 3, 0x7F, -1}
    n_pulse = 0; n_fin = 0;
    send_frame(2, DIM * DIM);
    drain("rand_drain");
    check("relu_window", first_val, 8'h7F);
    check("rand_count", n_pulse, N_OUT);

    // Ramp with random idle cycles
    n_pulse = 0; n_fin = 0;
    gaps_on = 1'b1;
    send_frame(0, DIM * DIM);
    gaps_on = 1'b0;
    drain("gap_drain");
    check("gap_count", n_pulse, N_OUT);
    check("gap_finished_count", n_fin, 1);
    check("gap_first", first_val, 27);

    // Mid-frame asynchronous reset, then a clean ramp frame
    send_frame(0, 300);
    @(negedge clk_i);
    pix_data_valid = 1'b0;
    @(negedge clk_i);
    check("pre_reset_drain", sb_q.size(), 0);
    #2 rst_ni = 1'b0;
    #1;
    check("async_rst_pixel", pixel_o, 0);
    check("async_rst_valid", pixel_o_valid, 0);
    check("async_rst_state", 32'(dut.state_q), 32'(IDLE));
    sb_q.delete();
    br = 0; bc = 0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    n_pulse = 0; n_fin = 0;
    send_frame(0, DIM * DIM);
    drain("post_reset_drain");
    check("post_reset_count", n_pulse, N_OUT);
    check("post_reset_first", first_val, 27);

    // Two frames back to back, no idle cycle between
    n_pulse = 0; n_fin = 0;
    send_frame(0, DIM * DIM);
    send_frame(0, DIM * DIM);
    drain("b2b_drain");
    check("b2b_count", n_pulse, 2 * N_OUT);
    check("b2b_finished_count", n_fin, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
